mc_controller: RTL

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_pkg.sv | 38 +++
 rtl/mc_controller_if.sv | 35 +++
 rtl/mc_controller_aludec.sv | 21 ++
 rtl/mc_controller.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS-style controller.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath/memory signal bundle.
interface mc_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       irwrite;
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       pcsrc;
    logic       jump;
    logic [2:0] alucontrol;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  op, funct, zero, mem_ready,
        output irwrite, pcen, iord, memwrite, memtoreg, regdst,
        output regwrite, alusrca, alusrcb, pcsrc, jump, alucontrol,
        output illegal, state
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  irwrite, pcen, iord, memwrite, memtoreg, regdst,
        input  regwrite, alusrca, alusrcb, pcsrc, jump, alucontrol,
        input  illegal, state
    );
endinterface

// File: rtl/mc_controller_aludec.sv
// R-type funct field to ALU operation decoder.
module aludec
    import mc_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [2:0] alucontrol_o
);

    always_comb begin
        alucontrol_o = ALU_ADD;
        case (funct_i)
            FN_ADD:  alucontrol_o = ALU_ADD;
            FN_SUB:  alucontrol_o = ALU_SUB;
            FN_AND:  alucontrol_o = ALU_AND;
            FN_OR:   alucontrol_o = ALU_OR;
            FN_SLT:  alucontrol_o = ALU_SLT;
            default: alucontrol_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle controller FSM: sequences fetch/decode/execute and drives
// datapath enables, with optional memory wait-states and a sticky illegal flag.
module mc_controller
    import mc_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input logic           clk,
    input logic           reset,
    mc_controller_if.master bus
);

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic       mem_rdy;
    logic [2:0] alu_exec;

    logic       irwrite_c, pcwrite_c, branch_c;
    logic       iord_c, memwrite_c, memtoreg_c;
    logic       regdst_c, regwrite_c, alusrca_c;
    logic [1:0] alusrcb_c;
    logic       pcsrc_c, jump_c;
    logic [2:0] alucontrol_c;

    assign mem_rdy = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

    aludec u_aludec (
        .funct_i      (bus.funct),
        .alucontrol_o (alu_exec)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        illegal_d    = illegal_q;
        irwrite_c    = 1'b0;
        pcwrite_c    = 1'b0;
        branch_c     = 1'b0;
        iord_c       = 1'b0;
        memwrite_c   = 1'b0;
        memtoreg_c   = 1'b0;
        regdst_c     = 1'b0;
        regwrite_c   = 1'b0;
        alusrca_c    = 1'b0;
        alusrcb_c    = 2'b00;
        pcsrc_c      = 1'b0;
        jump_c       = 1'b0;
        alucontrol_c = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                alusrcb_c = 2'b01;
                if (mem_rdy) begin
                    irwrite_c = 1'b1;
                    pcwrite_c = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrcb_c = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
                state_d   = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord_c = 1'b1;
                if (mem_rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg_c = 1'b1;
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                iord_c     = 1'b1;
                memwrite_c = 1'b1;
                if (mem_rdy) state_d = S_FETCH;
            end
            S_EXECUTE: begin
                alusrca_c    = 1'b1;
                alucontrol_c = alu_exec;
                state_d      = S_ALUWB;
            end
            S_ALUWB: begin
                regdst_c   = 1'b1;
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alusrca_c    = 1'b1;
                alucontrol_c = ALU_SUB;
                branch_c     = 1'b1;
                pcsrc_c      = 1'b1;
                state_d      = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                jump_c    = 1'b1;
                pcwrite_c = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Write enables are gated by reset so nothing commits while it is held.
    assign bus.irwrite    = irwrite_c & reset;
    assign bus.pcen       = (pcwrite_c | (branch_c & bus.zero)) & reset;
    assign bus.memwrite   = memwrite_c & reset;
    assign bus.regwrite   = regwrite_c & reset;
    assign bus.iord       = iord_c;
    assign bus.memtoreg   = memtoreg_c;
    assign bus.regdst     = regdst_c;
    assign bus.alusrca    = alusrca_c;
    assign bus.alusrcb    = alusrcb_c;
    assign bus.pcsrc      = pcsrc_c;
    assign bus.jump       = jump_c;
    assign bus.alucontrol = alucontrol_c;
    assign bus.illegal    = illegal_q;
    assign bus.state      = state_q;

endmodule
